// File: rtl/pipelined_adder_wrapper.sv
// pipelined_adder_wrapper: WIDTH-bit adder with carry-in, split into STAGES
// carry-chained slices behind a valid/ready pipeline with backpressure.
module pipelined_adder_wrapper #(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_cout,
    output logic               out_ovf,
    output logic [COUNT_W-1:0] tx_count
);
    localparam int SW = WIDTH / STAGES;

    // Index 0 of each chain is the input port, index k+1 is stage k's register.
    logic [STAGES:0]  v_ch;
    logic [STAGES:0]  c_ch;
    logic [WIDTH-1:0] a_ch   [STAGES+1];
    logic [WIDTH-1:0] b_ch   [STAGES+1];
    logic [WIDTH-1:0] sum_ch [STAGES+1];

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] stage_ready;

    assign v_ch[0]   = in_valid;
    assign c_ch[0]   = in_cin;
    assign a_ch[0]   = in_a;
    assign b_ch[0]   = in_b;
    assign sum_ch[0] = '0;
    assign valid     = v_ch[STAGES:1];

    // A stage may load if any stage from it to the output has room,
    // or the output is being drained this cycle.
    always_comb begin : ready_chain
        logic rdy;
        rdy         = out_ready;
        stage_ready = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy            = rdy || !valid[k];
            stage_ready[k] = rdy;
        end
    end

    assign in_ready = stage_ready[0] && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] nxt_sum;
        logic [SW:0]      slice;

        assign slice = {1'b0, a_ch[k][k*SW +: SW]}
                     + {1'b0, b_ch[k][k*SW +: SW]}
                     + {{SW{1'b0}}, c_ch[k]};

        always_comb begin
            nxt_sum                = sum_ch[k];
            nxt_sum[k*SW +: SW]    = slice[SW-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                sum_q <= '0;
            end else if (stage_ready[k]) begin
                v_q   <= v_ch[k];
                c_q   <= slice[SW];
                a_q   <= a_ch[k];
                b_q   <= b_ch[k];
                sum_q <= nxt_sum;
            end
        end

        assign v_ch[k+1]   = v_q;
        assign c_ch[k+1]   = c_q;
        assign a_ch[k+1]   = a_q;
        assign b_ch[k+1]   = b_q;
        assign sum_ch[k+1] = sum_q;
    end

    assign out_valid = v_ch[STAGES];
    assign out_cout  = c_ch[STAGES];
    assign out_a     = a_ch[STAGES];
    assign out_b     = b_ch[STAGES];
    assign out_sum   = sum_ch[STAGES];
    assign out_ovf   = (out_a[WIDTH-1] == out_b[WIDTH-1])
                    && (out_sum[WIDTH-1] != out_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count <= '0;
        end else if (out_valid && out_ready) begin
            tx_count <= tx_count + 1'b1;
        end
    end
endmodule
